// File: rtl/rr_grant_arbiter_if.sv
// Request/grant bundle between a group of requesters and rr_grant_arbiter.
interface rr_grant_arbiter_if #(
    parameter int unsigned NUM_REQUESTERS = 4
);
    logic [NUM_REQUESTERS-1:0] request;
    logic                      grant_done;
    logic [NUM_REQUESTERS-1:0] grant_oh;
    logic                      grant_valid;

    modport master (
        output request,
        output grant_done,
        input  grant_oh,
        input  grant_valid
    );

    modport slave (
        input  request,
        input  grant_done,
        output grant_oh,
        output grant_valid
    );
endinterface

// File: rtl/rr_grant_arbiter.sv
// Registered round-robin arbiter: a one-hot grant stays locked to its owner
// until grant_done, then re-arbitrates back-to-back with the owner masked once.
module rr_grant_arbiter #(
    parameter int unsigned NUM_REQUESTERS = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    rr_grant_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQUESTERS - 1);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [NUM_REQUESTERS-1:0] grant;
    logic [NUM_REQUESTERS-1:0] grant_next;
    logic [PTR_W-1:0]          ptr;
    logic [PTR_W-1:0]          ptr_next;
    logic [PTR_W-1:0]          owner;
    logic [PTR_W-1:0]          owner_wrap;

    // Two passes (bits at/above start, then any bit) give the wrapped scan
    // without computed indices.
    function automatic logic [NUM_REQUESTERS-1:0] pick(
        input logic [NUM_REQUESTERS-1:0] req,
        input logic [PTR_W-1:0]          start
    );
        logic [NUM_REQUESTERS-1:0] onehot;
        logic                      found;
        onehot = '0;
        found  = 1'b0;
        for (int unsigned j = 0; j < NUM_REQUESTERS; j++) begin
            if (!found && req[j] && (j >= 32'(start))) begin
                onehot[j] = 1'b1;
                found     = 1'b1;
            end
        end
        for (int unsigned j = 0; j < NUM_REQUESTERS; j++) begin
            if (!found && req[j]) begin
                onehot[j] = 1'b1;
                found     = 1'b1;
            end
        end
        return onehot;
    endfunction

    always_comb begin
        owner = '0;
        for (int unsigned j = 0; j < NUM_REQUESTERS; j++) begin
            if (grant[j]) begin
                owner = owner | j[PTR_W-1:0];
            end
        end
    end

    assign owner_wrap = (owner == LAST) ? '0 : owner + 1'b1;

    always_comb begin
        state_next = state;
        grant_next = grant;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (|bus.request) begin
                    grant_next = pick(bus.request, ptr);
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (bus.grant_done) begin
                    ptr_next   = owner_wrap;
                    grant_next = pick(bus.request & ~grant, owner_wrap);
                    state_next = (|grant_next) ? LOCKED : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= '0;
        end else begin
            state <= state_next;
            grant <= grant_next;
            ptr   <= ptr_next;
        end
    end

    assign bus.grant_oh    = grant;
    assign bus.grant_valid = (state == LOCKED);
endmodule
